// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job controller.
package gcd_pkg;

  localparam int unsigned GCD_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CALC   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Subtractor operand selects, packed as {sel1, sel2}.
  localparam logic [1:0] SUB_NONE      = 2'b00;
  localparam logic [1:0] SUB_A_MINUS_B = 2'b01;
  localparam logic [1:0] SUB_B_MINUS_A = 2'b10;

endpackage : gcd_pkg

// File: rtl/gcd_rr_arbiter.sv
// Two-way request arbiter. With GCD_ARB_RR_EN defined it is round-robin
// (pointer moves on each accepted grant); otherwise requester 0 has fixed priority.
module gcd_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef GCD_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the requester not served last wins.
  always_comb begin
    grant  = req;
    last_d = last_q;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Reset as if requester 1 was served last, so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_ok;

  always_comb begin
    grant = req;
    if (req[0]) begin
      grant[1] = 1'b0;
    end
  end

  assign unused_ok = ^{clk, rst, advance};
`endif

endmodule : gcd_rr_arbiter

// File: rtl/gcd_arbiter.sv
// GCD job controller: arbitrates two requesters and sequences an external subtractive
// GCD datapath. Define GCD_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned DW = GCD_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] result,
  output logic          busy,
  output logic [DW-1:0] data,
  output logic          ldA,
  output logic          ldB,
  output logic          sel_in,
  output logic          sel1,
  output logic          sel2,
  input  logic          gt,
  input  logic          lt,
  input  logic          eq,
  input  logic [DW-1:0] dp_a
);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] result_q, result_d;
  logic [1:0]    req_vec;
  logic [1:0]    grant;
  logic [DW-1:0] pick_a, pick_b;
  logic          job_start;

  // Requests are masked during reset so no grant can leak out combinationally.
  assign req_vec   = {req1, req0} & {2{~rst}};
  assign job_start = (state_q == ST_IDLE) && (grant != 2'b00);
  assign pick_a    = grant[1] ? a1 : a0;
  assign pick_b    = grant[1] ? b1 : b0;

  gcd_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vec),
    .advance (job_start),
    .grant   (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    busy         = (state_q != ST_IDLE);
    data         = '0;
    ldA          = 1'b0;
    ldB          = 1'b0;
    sel_in       = 1'b0;
    {sel1, sel2} = SUB_NONE;

    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          gnt0    = grant[0];
          gnt1    = grant[1];
          owner_d = grant[1];
          a_d     = pick_a;
          b_d     = pick_b;
          // A zero operand skips the datapath; a|b is the gcd in that case.
          if ((pick_a == '0) || (pick_b == '0)) begin
            result_d = pick_a | pick_b;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        data    = a_q;
        sel_in  = 1'b1;
        ldA     = 1'b1;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        data    = b_q;
        sel_in  = 1'b1;
        ldB     = 1'b1;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        if (eq) begin
          result_d = dp_a;
          state_d  = ST_DONE;
        end else if (gt) begin
          {sel1, sel2} = SUB_A_MINUS_B;
          ldA          = 1'b1;
        end else if (lt) begin
          {sel1, sel2} = SUB_B_MINUS_A;
          ldB          = 1'b1;
        end
      end
      ST_DONE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule : gcd_arbiter
